// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// button_conditioner: synchronizes and debounces 2 active-low keys and N_SW switches.
// Keys add press/release strobes and 8-bit press counters. Rev 1.0
// ============================================================================
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int N_SW            = 10
) (
  input  logic            clk_clk,
  input  logic            reset_reset,
  input  logic [1:0]      key_raw_n,
  input  logic [N_SW-1:0] sw_raw,
  output logic [1:0]      button_out,
  output logic [N_SW-1:0] switch_out,
  output logic [1:0]      press_pulse,
  output logic [1:0]      release_pulse,
  output logic [15:0]     press_count
);

  localparam int                c_CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RELEASED     = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } key_state_t;

  for (genvar k = 0; k < 2; k++) begin : g_key
    logic [1:0]         r_sync;
    logic [c_CNT_W-1:0] r_cnt;
    key_state_t         r_state;
    key_state_t         w_state_nxt;
    logic               w_sync;
    logic               w_stable;
    logic               w_at_limit;
    logic               w_press_evt;
    logic               w_release_evt;
    logic               w_btn_nxt;
    logic               r_btn;
    logic               r_press;
    logic               r_release;
    logic [7:0]         r_presses;

    // The FSM state doubles as the key's stable register (1 = released).
    assign w_sync     = r_sync[1];
    assign w_stable   = (r_state == S_RELEASED) || (r_state == S_PRESS_WAIT);
    assign w_at_limit = (r_cnt == c_LIMIT);

    always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
        r_sync <= 2'b11;
        r_cnt  <= '0;
      end else begin
        r_sync <= {r_sync[0], key_raw_n[k]};
        if ((w_sync == w_stable) || w_at_limit) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    always_comb begin
      w_state_nxt   = r_state;
      w_press_evt   = 1'b0;
      w_release_evt = 1'b0;
      case (r_state)
        S_RELEASED: begin
          if (!w_sync) w_state_nxt = S_PRESS_WAIT;
        end
        S_PRESS_WAIT: begin
          if (w_sync) begin
            w_state_nxt = S_RELEASED;
          end else if (w_at_limit) begin
            w_state_nxt = S_PRESSED;
            w_press_evt = 1'b1;
          end
        end
        S_PRESSED: begin
          if (w_sync) w_state_nxt = S_RELEASE_WAIT;
        end
        S_RELEASE_WAIT: begin
          if (!w_sync) begin
            w_state_nxt = S_PRESSED;
          end else if (w_at_limit) begin
            w_state_nxt   = S_RELEASED;
            w_release_evt = 1'b1;
          end
        end
        default: w_state_nxt = S_RELEASED;
      endcase
      w_btn_nxt = (w_state_nxt == S_RELEASED) || (w_state_nxt == S_PRESS_WAIT);
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
        r_state   <= S_RELEASED;
        r_btn     <= 1'b1;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_presses <= 8'd0;
      end else begin
        r_state   <= w_state_nxt;
        r_btn     <= w_btn_nxt;
        r_press   <= w_press_evt;
        r_release <= w_release_evt;
        if (w_press_evt) r_presses <= r_presses + 8'd1;
      end
    end

    assign button_out[k]        = r_btn;
    assign press_pulse[k]       = r_press;
    assign release_pulse[k]     = r_release;
    assign press_count[8*k +: 8] = r_presses;
  end

  for (genvar s = 0; s < N_SW; s++) begin : g_sw
    logic [1:0]         r_sync;
    logic               r_stable;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
        r_sync   <= 2'b00;
        r_stable <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_sync <= {r_sync[0], sw_raw[s]};
        if (r_sync[1] == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == c_LIMIT) begin
          r_stable <= r_sync[1];
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign switch_out[s] = r_stable;
  end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// tb_button_conditioner: directed and random stimulus against a reference model
// that accepts a level once the last D synchronized samples all disagree with it.
module tb_button_conditioner;
  localparam int D   = 4;
  localparam int NSW = 10;
  localparam int NCH = 2 + NSW;
  localparam logic [NCH-1:0] RV = {{NSW{1'b0}}, 2'b11};

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] raw = RV;
  logic [1:0]     button_out;
  logic [NSW-1:0] switch_out;
  logic [1:0]     press_pulse;
  logic [1:0]     release_pulse;
  logic [15:0]    press_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Channel order: bits [1:0] keys (raw level), bits [NCH-1:2] switches.
  logic [NCH-1:0] hist[$];
  logic [NCH-1:0] m_stable;
  logic [1:0]     m_press;
  logic [1:0]     m_release;
  logic [7:0]     m_cnt0;
  logic [7:0]     m_cnt1;

  button_conditioner #(.DEBOUNCE_CYCLES(D), .N_SW(NSW)) dut (
    .clk_clk      (clk),
    .reset_reset  (rst),
    .key_raw_n    (raw[1:0]),
    .sw_raw       (raw[NCH-1:2]),
    .button_out   (button_out),
    .switch_out   (switch_out),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .press_count  (press_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < D + 2; i++) hist.push_back(RV);
    m_stable  = RV;
    m_press   = 2'b00;
    m_release = 2'b00;
    m_cnt0    = 8'd0;
    m_cnt1    = 8'd0;
  endtask

  // Edge t sees synchronized value raw[t-2]; a flip needs raw[t-1-D..t-2] all different.
  task automatic model_edge(input logic [NCH-1:0] smp);
    int   last;
    logic all_diff;
    hist.push_back(smp);
    if (hist.size() > D + 3) void'(hist.pop_front());
    last      = hist.size() - 1;
    m_press   = 2'b00;
    m_release = 2'b00;
    for (int c = 0; c < NCH; c++) begin
      all_diff = 1'b1;
      for (int j = last - 1 - D; j <= last - 2; j++)
        if (hist[j][c] == m_stable[c]) all_diff = 1'b0;
      if (all_diff) begin
        m_stable[c] = ~m_stable[c];
        if (c < 2) begin
          if (m_stable[c] == 1'b0) begin
            m_press[c] = 1'b1;
            if (c == 0) m_cnt0 = m_cnt0 + 8'd1;
            else        m_cnt1 = m_cnt1 + 8'd1;
          end else begin
            m_release[c] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("button_out",    32'(button_out),    32'(m_stable[1:0]));
    chk("switch_out",    32'(switch_out),    32'(m_stable[NCH-1:2]));
    chk("press_pulse",   32'(press_pulse),   32'(m_press));
    chk("release_pulse", 32'(release_pulse), 32'(m_release));
    chk("press_count",   32'(press_count),   32'({m_cnt1, m_cnt0}));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge(raw);
    @(negedge clk);
    check_all();
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int pulses;
    int at;

    model_reset();
    hold(2);
    chk("reset_button", 32'(button_out), 32'h3);
    chk("reset_switch", 32'(switch_out), 32'h0);
    rst = 1'b0;
    hold(3);

    // Clean press on key0: accepted on the 6th edge.
    raw[0] = 1'b0;
    hold(5);
    chk("press_before_6", 32'(button_out[0]), 32'h1);
    tick();
    chk("press_at_6", 32'(button_out[0]), 32'h0);
    chk("press_pulse_at_6", 32'(press_pulse[0]), 32'h1);
    tick();
    chk("press_pulse_gone", 32'(press_pulse[0]), 32'h0);
    chk("press_count_1", 32'(press_count), 32'h0001);
    raw[0] = 1'b1;
    hold(8);

    // Bouncing press on key1.
    raw[1] = 1'b0; hold(2);
    raw[1] = 1'b1; hold(2);
    raw[1] = 1'b0;
    pulses = 0;
    at     = 0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (press_pulse[1]) begin
        pulses++;
        at = i;
      end
    end
    chk("bounce_pulses", 32'(pulses), 32'd1);
    chk("bounce_latency", 32'(at), 32'd6);
    raw[1] = 1'b1;
    hold(8);

    // Release with a short glitch on key0.
    raw[0] = 1'b0; hold(8);
    raw[0] = 1'b1; hold(3);
    raw[0] = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (release_pulse[0] || button_out[0]) pulses++;
    end
    chk("glitch_ignored", 32'(pulses), 32'd0);
    raw[0] = 1'b1;
    hold(5);
    chk("release_before_6", 32'(release_pulse[0]), 32'h0);
    tick();
    chk("release_at_6", 32'(release_pulse[0]), 32'h1);
    chk("released_btn", 32'(button_out[0]), 32'h1);
    hold(4);

    // Simultaneous switches and keys.
    raw = {10'h3FF, 2'b00};
    hold(6);
    chk("simul_switch", 32'(switch_out), 32'h3FF);
    chk("simul_pulses", 32'(press_pulse), 32'h3);
    raw = {10'h008, 2'b11};
    hold(10);

    // Reset while key0 is at debounce count 2; switch 3 held through reset.
    raw[0] = 1'b0;
    hold(4);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_button", 32'(button_out), 32'h3);
    chk("async_rst_switch", 32'(switch_out), 32'h0);
    chk("async_rst_count", 32'(press_count), 32'h0);
    tick();
    rst = 1'b0;
    hold(5);
    chk("rst_press_before_6", 32'(button_out[0]), 32'h1);
    chk("rst_switch_before_6", 32'(switch_out), 32'h0);
    tick();
    chk("rst_press_at_6", 32'(press_pulse[0]), 32'h1);
    chk("rst_switch_at_6", 32'(switch_out), 32'h008);
    raw = RV;
    hold(8);

    // Counter wrap: 256 presses on key0 from a fresh reset.
    #2 rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
    for (int p = 1; p <= 256; p++) begin
      raw[0] = 1'b0; hold(7);
      raw[0] = 1'b1; hold(7);
      if (p == 255) chk("count_255", 32'(press_count[7:0]), 32'd255);
    end
    chk("wrap_key0", 32'(press_count[7:0]), 32'd0);
    chk("wrap_key1", 32'(press_count[15:8]), 32'd0);

    // Random bouncing on all channels, with quiet stretches and one async reset.
    for (int i = 0; i < 700; i++) begin
      if (((i / 50) % 2) == 0) begin
        if ($urandom_range(2) == 0) raw[$urandom_range(NCH - 1)] ^= 1'b1;
      end else begin
        if ($urandom_range(15) == 0) raw[$urandom_range(NCH - 1)] ^= 1'b1;
      end
      if (i == 420) begin
        #2 rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
